// File: rtl/pulse_code_gen.sv
// Transmit responder for the sequencer GEN/GEN_OVER handshake: one binary-phase-coded
// pulse burst per request, with guard intervals on the T/R switch around the chips.
//
// state | meaning
// IDLE  | ready, GEN_OVER=1, waiting for GEN
// PRE   | T/R settling before the first chip
// CHIP  | emitting chips, MSB of the code field first
// POST  | T/R hold after the last chip
// DONE  | burst finished, waiting for GEN to drop
module pulse_code_gen #(
  parameter int GUARD_PRE  = 20,
  parameter int GUARD_POST = 20
) (
  input  logic        CLOCK_10M,
  input  logic        RESET_N,
  input  logic        GEN,
  output logic        GEN_OVER,
  input  logic        RF_OUTPUT_EN,
  input  logic [31:0] CODE,
  input  logic [7:0]  CODE_LEN,
  input  logic [15:0] PULSE_LEN,
  output logic        TR,
  output logic        RF_GATE,
  output logic        PHASE,
  output logic        CHIP_STROBE,
  output logic        BUSY
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_CHIP, S_POST, S_DONE} state_t;

  localparam logic [15:0] PRE_M1  = (GUARD_PRE  > 0) ? 16'(GUARD_PRE - 1)  : 16'd0;
  localparam logic [15:0] POST_M1 = (GUARD_POST > 0) ? 16'(GUARD_POST - 1) : 16'd0;

  state_t      state_q, state_d;
  logic [15:0] cyc_q, cyc_d;
  logic [5:0]  chip_q, chip_d;
  logic [31:0] code_q, code_d;
  logic [5:0]  n_q, n_d;
  logic [15:0] len_q, len_d;
  logic        en_q, en_d;
  logic        gen_over_q, gen_over_d;
  logic        busy_q, busy_d;
  logic        tr_q, tr_d;
  logic        rf_gate_q, rf_gate_d;
  logic        phase_q, phase_d;
  logic        strobe_q, strobe_d;
  logic [5:0]  n_in;
  logic [15:0] len_in;
  logic        active;

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    chip_d   = chip_q;
    code_d   = code_q;
    n_d      = n_q;
    len_d    = len_q;
    en_d     = en_q;
    strobe_d = 1'b0;
    n_in     = (CODE_LEN > 8'd32) ? 6'd32 : CODE_LEN[5:0];
    len_in   = (PULSE_LEN == 16'd0) ? 16'd1 : PULSE_LEN;

    case (state_q)
      S_IDLE: begin
        if (GEN) begin
          code_d = CODE;
          n_d    = n_in;
          len_d  = len_in;
          en_d   = RF_OUTPUT_EN;
          if (GUARD_PRE > 0) begin
            state_d = S_PRE;
            cyc_d   = PRE_M1;
          end else if (n_in != 6'd0) begin
            state_d  = S_CHIP;
            cyc_d    = len_in - 16'd1;
            chip_d   = n_in - 6'd1;
            strobe_d = 1'b1;
          end else if (GUARD_POST > 0) begin
            state_d = S_POST;
            cyc_d   = POST_M1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_PRE: begin
        if (cyc_q != 16'd0) begin
          cyc_d = cyc_q - 16'd1;
        end else if (n_q != 6'd0) begin
          state_d  = S_CHIP;
          cyc_d    = len_q - 16'd1;
          chip_d   = n_q - 6'd1;
          strobe_d = 1'b1;
        end else if (GUARD_POST > 0) begin
          state_d = S_POST;
          cyc_d   = POST_M1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_CHIP: begin
        // chip_q counts remaining chips, so it doubles as the code bit index
        if (cyc_q != 16'd0) begin
          cyc_d = cyc_q - 16'd1;
        end else if (chip_q != 6'd0) begin
          chip_d   = chip_q - 6'd1;
          cyc_d    = len_q - 16'd1;
          strobe_d = 1'b1;
        end else if (GUARD_POST > 0) begin
          state_d = S_POST;
          cyc_d   = POST_M1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_POST: begin
        if (cyc_q != 16'd0) begin
          cyc_d = cyc_q - 16'd1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!GEN) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs follow the next state so every pin is a plain flop
    active     = (state_d == S_PRE) || (state_d == S_CHIP) || (state_d == S_POST);
    gen_over_d = (state_d == S_IDLE);
    busy_d     = ~gen_over_d;
    tr_d       = en_d & active;
    rf_gate_d  = en_d & (state_d == S_CHIP);
    phase_d    = (state_d == S_CHIP) & code_d[chip_d[4:0]];
  end

  always_ff @(posedge CLOCK_10M) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      cyc_q      <= 16'd0;
      chip_q     <= 6'd0;
      code_q     <= 32'd0;
      n_q        <= 6'd0;
      len_q      <= 16'd0;
      en_q       <= 1'b0;
      gen_over_q <= 1'b1;
      busy_q     <= 1'b0;
      tr_q       <= 1'b0;
      rf_gate_q  <= 1'b0;
      phase_q    <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      chip_q     <= chip_d;
      code_q     <= code_d;
      n_q        <= n_d;
      len_q      <= len_d;
      en_q       <= en_d;
      gen_over_q <= gen_over_d;
      busy_q     <= busy_d;
      tr_q       <= tr_d;
      rf_gate_q  <= rf_gate_d;
      phase_q    <= phase_d;
      strobe_q   <= strobe_d;
    end
  end

  assign GEN_OVER    = gen_over_q;
  assign BUSY        = busy_q;
  assign TR          = tr_q;
  assign RF_GATE     = rf_gate_q;
  assign PHASE       = phase_q;
  assign CHIP_STROBE = strobe_q;

endmodule
